// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction memory port, branch redirect and the decode handshake.
// master = ifetch side, slave = memory/execute/decode side.
interface ifetch_if #(parameter int XLEN = 32);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            imem_err_i;
  logic            branch_v_i;
  logic [XLEN-1:0] branch_target_i;
  logic            line0_valid_o;
  logic            line0_ready_i;
  logic [XLEN-1:0] line0_instr_o;
  logic [XLEN-1:0] line0_pc_o;
  logic            line0_fetch_fault_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
    input  branch_v_i, branch_target_i,
    output line0_valid_o, line0_instr_o, line0_pc_o, line0_fetch_fault_o,
    input  line0_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
    output branch_v_i, branch_target_i,
    input  line0_valid_o, line0_instr_o, line0_pc_o, line0_fetch_fault_o,
    output line0_ready_i
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues credit-limited in-order imem requests, buffers results for decode.
// Optional feature macro IFETCH_BYPASS_EN: forward a response straight to decode when the buffer is empty.
module ifetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input logic      clk,
  input logic      resetn,
  ifetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d, pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  entry_t          fifo_q [FIFO_DEPTH];
  logic [XLEN-1:0] pcq_q  [FIFO_DEPTH];

  logic [CW+1:0] inflight;
  logic          req, grant, drop, take, push, pop, empty, valid;
  entry_t        resp, head;
  logic          unused_tgt_lsb;

  // Every in-flight or buffered word holds a FIFO slot, so a granted word always has room.
  assign inflight = {2'b00, out_q} + {2'b00, cnt_q} + {2'b00, disc_q};
  assign req      = resetn && !bus.branch_v_i && (inflight < (CW+2)'(FIFO_DEPTH));
  assign grant    = req && bus.imem_gnt_i;
  assign drop     = bus.imem_rvalid_i && (bus.branch_v_i || disc_q != '0);
  assign take     = bus.imem_rvalid_i && !drop;
  assign empty    = (cnt_q == '0);
  assign resp     = '{pc: pcq_q[pq_rd_q],
                      instr: bus.imem_err_i ? '0 : bus.imem_rdata_i,
                      fault: bus.imem_err_i};

`ifdef IFETCH_BYPASS_EN
  logic byp;
  assign byp   = take && empty;
  assign head  = byp ? resp : fifo_q[rd_q];
  assign valid = !empty || byp;
  assign push  = take && !(byp && bus.line0_ready_i);
  assign pop   = !empty && bus.line0_ready_i && !bus.branch_v_i;
`else
  assign head  = fifo_q[rd_q];
  assign valid = !empty;
  assign push  = take;
  assign pop   = valid && bus.line0_ready_i && !bus.branch_v_i;
`endif

  assign bus.imem_req_o          = req;
  assign bus.imem_addr_o         = fetch_pc_q;
  assign bus.line0_valid_o       = valid;
  assign bus.line0_instr_o       = valid ? head.instr : '0;
  assign bus.line0_pc_o          = valid ? head.pc    : '0;
  assign bus.line0_fetch_fault_o = valid && head.fault;
  assign unused_tgt_lsb          = ^bus.branch_target_i[1:0];

  always_comb begin
    fetch_pc_d = grant ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    out_d      = out_q + CW'(grant) - CW'(take);
    disc_d     = disc_q - CW'(drop);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    pq_wr_d    = pq_wr_q + AW'(grant);
    pq_rd_d    = pq_rd_q + AW'(take);
    if (bus.branch_v_i) begin
      // Everything still due back from memory belongs to the old path.
      fetch_pc_d = {bus.branch_target_i[XLEN-1:2], 2'b00};
      disc_d     = out_q + disc_q - CW'(bus.imem_rvalid_i);
      out_d      = '0;
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)  fifo_q[wr_q]   <= resp;
    if (grant) pcq_q[pq_wr_q] <= fetch_pc_q;
  end

  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!resetn)
    bus.imem_rvalid_i |-> (out_q != '0 || disc_q != '0));
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed cycle table plus randomized traffic against an epoch-based reference model.
module tb_ifetch;
  localparam int XLEN = 32;
  localparam int D    = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ifetch_if #(.XLEN(XLEN)) bus();
  ifetch #(.XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct { logic [31:0] addr; int ep; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;
  typedef struct {
    int gnt; int rv; int err; int br; logic [31:0] tgt; int rdy;
    int req; logic [31:0] addr; int vld; logic [31:0] pc; int flt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  mreq_t mq[$];      // requests granted by memory, response still due
  ent_t  expq[$];    // words decode is owed, in order
  int    ep = 0;
  logic [31:0] exp_pc = 32'h0;
  int c_gnt, c_rv, c_err, c_br, c_rdy;
  logic [31:0] c_tgt;
  vec_t tbl[26];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int gnt, input int rv, input int err, input int br,
                       input logic [31:0] tgt, input int rdy);
    c_gnt = gnt; c_rv = (rv != 0 && mq.size() > 0) ? 1 : 0;
    c_err = (c_rv != 0 && err != 0) ? 1 : 0;
    c_br = br; c_tgt = tgt; c_rdy = rdy;
    bus.imem_gnt_i      = (c_gnt != 0);
    bus.imem_rvalid_i   = (c_rv != 0);
    bus.imem_rdata_i    = (c_rv != 0) ? instr_of(mq[0].addr) : 32'h0;
    bus.imem_err_i      = (c_err != 0);
    bus.branch_v_i      = (c_br != 0);
    bus.branch_target_i = c_tgt;
    bus.line0_ready_i   = (c_rdy != 0);
  endtask

  // Called mid-cycle: checks outputs, then advances the model by what the coming edge commits.
  task automatic model_cycle();
    int   nb;
    logic exp_req, exp_v;
    mreq_t f;
    exp_req = (c_br == 0) && (mq.size() + expq.size() < D);
    check("req", 32'(bus.imem_req_o), 32'(exp_req));
    if (bus.imem_req_o) check("addr", bus.imem_addr_o, exp_pc);
    nb = expq.size();
    if (c_rv != 0) begin
      f = mq.pop_front();
      if (c_br == 0 && f.ep == ep)
        expq.push_back('{f.addr, (c_err != 0) ? 32'h0 : instr_of(f.addr), c_err != 0});
    end
`ifdef IFETCH_BYPASS_EN
    exp_v = expq.size() != 0;
`else
    exp_v = nb != 0;
`endif
    check("valid", 32'(bus.line0_valid_o), 32'(exp_v));
    if (bus.line0_valid_o && expq.size() > 0) begin
      check("pc", bus.line0_pc_o, expq[0].pc);
      check("instr", bus.line0_instr_o, expq[0].instr);
      check("fault", 32'(bus.line0_fetch_fault_o), 32'(expq[0].fault));
      if (c_rdy != 0 && c_br == 0) void'(expq.pop_front());
    end
    if (c_br != 0) begin
      expq.delete();
      ep++;
      exp_pc = c_tgt & ~32'h3;
    end else if (bus.imem_req_o && c_gnt != 0) begin
      mq.push_back('{exp_pc, ep});
      exp_pc += 32'h4;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req_o), 32'h0);
    check({tag, "_addr"}, bus.imem_addr_o, 32'h0);
    check({tag, "_valid"}, 32'(bus.line0_valid_o), 32'h0);
    check({tag, "_instr"}, bus.line0_instr_o, 32'h0);
    check({tag, "_pc"}, bus.line0_pc_o, 32'h0);
    check({tag, "_fault"}, 32'(bus.line0_fetch_fault_o), 32'h0);
  endtask

  initial begin
    // gnt rv err br tgt rdy | req addr vld pc flt
    tbl = '{
      '{1,0,0,0,32'h0,0,   1,32'h00, 0,32'h0,0},
      '{1,1,0,0,32'h0,0,   1,32'h04, 0,32'h0,0},
      '{1,1,0,0,32'h0,0,   1,32'h08, 1,32'h0,0},
      '{1,1,1,0,32'h0,0,   1,32'h0C, 1,32'h0,0},
      '{1,1,0,0,32'h0,0,   0,32'h10, 1,32'h0,0},
      '{1,0,0,0,32'h0,0,   0,32'h10, 1,32'h0,0},
      '{1,0,0,0,32'h0,1,   0,32'h10, 1,32'h0,0},
      '{1,0,0,0,32'h0,1,   1,32'h10, 1,32'h4,0},
      '{0,1,0,0,32'h0,1,   1,32'h14, 1,32'h8,1},
      '{1,0,0,0,32'h0,1,   1,32'h14, 1,32'hC,0},
      '{1,0,0,0,32'h0,1,   1,32'h18, 1,32'h10,0},
      '{1,0,0,1,32'h100,1, 0,32'h1C, 0,32'h0,0},
      '{1,1,0,0,32'h0,1,   1,32'h100,0,32'h0,0},
      '{0,1,0,0,32'h0,1,   1,32'h104,0,32'h0,0},
      '{0,1,0,0,32'h0,1,   1,32'h104,0,32'h0,0},
      '{0,0,0,0,32'h0,0,   1,32'h104,1,32'h100,0},
      '{0,0,0,0,32'h0,0,   1,32'h104,1,32'h100,0},
      '{1,0,0,0,32'h0,0,   1,32'h104,1,32'h100,0},
      '{1,1,0,1,32'h203,1, 0,32'h108,1,32'h100,0},
      '{0,0,0,0,32'h0,1,   1,32'h200,0,32'h0,0},
      '{0,0,0,0,32'h0,1,   1,32'h200,0,32'h0,0},
      '{0,0,0,0,32'h0,1,   1,32'h200,0,32'h0,0},
      '{1,0,0,0,32'h0,1,   1,32'h200,0,32'h0,0},
      '{0,1,0,0,32'h0,1,   1,32'h204,0,32'h0,0},
      '{0,0,0,0,32'h0,1,   1,32'h204,1,32'h200,0},
      '{0,0,0,0,32'h0,1,   1,32'h204,0,32'h0,0}
    };

    drive(0, 0, 0, 0, 32'h0, 0);
    repeat (3) begin
      @(negedge clk);
      reset_checks("rst");
    end
    @(posedge clk); #1;
    resetn = 1'b1;

`ifndef IFETCH_BYPASS_EN
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].err, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("tbl%0d_req", i), 32'(bus.imem_req_o), 32'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i), bus.imem_addr_o, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), 32'(bus.line0_valid_o), 32'(tbl[i].vld));
      if (tbl[i].vld != 0) begin
        check($sformatf("tbl%0d_pc", i), bus.line0_pc_o, tbl[i].pc);
        check($sformatf("tbl%0d_fault", i), 32'(bus.line0_fetch_fault_o), 32'(tbl[i].flt));
        check($sformatf("tbl%0d_instr", i), bus.line0_instr_o,
              (tbl[i].flt != 0) ? 32'h0 : instr_of(tbl[i].pc));
      end
      model_cycle();
      @(posedge clk); #1;
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        resetn = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        reset_checks("midrst");
        mq.delete(); expq.delete(); exp_pc = 32'h0;
        @(posedge clk); #1;
        resetn = 1'b1;
      end
      drive(($urandom_range(0, 9) < 7) ? 1 : 0,
            ($urandom_range(0, 9) < 6) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 19) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
            ($urandom_range(0, 9) < 6) ? 1 : 0);
      @(negedge clk);
      model_cycle();
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
